sdram_line_port: RTL

SDRAM_LINE_PORT -- requirements
Module: sdram_line_port

---
 rtl/sdram_pkg.sv | 31 +++
 rtl/sdram_line_port.sv | 115 +++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM geometry, the line-port state type and the mask priority encoder.
package sdram_pkg;

   localparam int LINE_WORDS  = 8;
   localparam int WORD_W      = 16;
   localparam int LINE_W      = LINE_WORDS * WORD_W;
   localparam int CHIP_W      = 1;
   localparam int BANK_W      = 2;
   localparam int ROW_W       = 13;
   localparam int COL_W       = 10;
   localparam int ADDR_W      = CHIP_W + BANK_W + ROW_W + COL_W;
   localparam int OFFS_W      = $clog2(LINE_WORDS);
   localparam int LINE_ADDR_W = ADDR_W - OFFS_W;

   typedef enum logic [2:0] {
      LP_IDLE,
      LP_RD_CMD,
      LP_RD_DATA,
      LP_RSP,
      LP_WR_CMD
   } line_state_t;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [OFFS_W-1:0] lowest_set(input logic [LINE_WORDS-1:0] mask);
      lowest_set = '0;
      for (int i = LINE_WORDS - 1; i >= 0; i--) begin
         if (mask[i]) lowest_set = OFFS_W'(i);
      end
   endfunction

endpackage

// File: rtl/sdram_line_port.sv
// Cache-line port onto a word-wide SDRAM controller: one 8-beat burst per read line,
// one word command per enabled mask bit per write line.
module sdram_line_port import sdram_pkg::*; (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [LINE_ADDR_W-1:0] req_line,
   input  logic [LINE_W-1:0]      req_wdata,
   input  logic [LINE_WORDS-1:0]  req_wmask,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [LINE_W-1:0]      rsp_rdata,
   output logic                   wr_done,
   output logic                   err_stray,
   output logic                   sd_read,
   output logic                   sd_write,
   output logic [ADDR_W-1:0]      sd_addr,
   input  logic                   sd_cmd_ready,
   output logic [WORD_W-1:0]      sd_wdata,
   input  logic [WORD_W-1:0]      sd_rdata,
   input  logic                   sd_rdata_val
);

   // state      | meaning
   // LP_IDLE    | waiting for a client request
   // LP_RD_CMD  | read command held until the controller takes it
   // LP_RD_DATA | collecting 8 read beats
   // LP_RSP     | read line presented until the client consumes it
   // LP_WR_CMD  | issuing one write per remaining mask bit, lowest first

   line_state_t             state, state_nxt;
   logic [LINE_ADDR_W-1:0]  line_q;
   logic [LINE_W-1:0]       wdata_q;
   logic [LINE_W-1:0]       rdata_q;
   logic [LINE_WORDS-1:0]   mask_q, mask_nxt, idx_bit;
   logic [OFFS_W-1:0]       idx;
   logic [OFFS_W-1:0]       beat_cnt;
   logic                    wr_done_q;
   logic                    err_stray_q;

   always_comb begin
      state_nxt = state;
      mask_nxt  = mask_q;
      idx       = lowest_set(mask_q);
      idx_bit   = LINE_WORDS'(1) << idx;
      case (state)
         LP_IDLE: begin
            if (req_valid) begin
               state_nxt = req_write ? LP_WR_CMD : LP_RD_CMD;
               mask_nxt  = req_write ? req_wmask : '0;
            end
         end
         LP_RD_CMD: begin
            if (sd_cmd_ready) state_nxt = LP_RD_DATA;
         end
         LP_RD_DATA: begin
            if (sd_rdata_val && beat_cnt == OFFS_W'(LINE_WORDS - 1)) state_nxt = LP_RSP;
         end
         LP_RSP: begin
            if (rsp_ready) state_nxt = LP_IDLE;
         end
         LP_WR_CMD: begin
            if (sd_cmd_ready && mask_q != '0) mask_nxt = mask_q & ~idx_bit;
            // An empty mask (all words disabled) falls straight through here.
            if (mask_nxt == '0) state_nxt = LP_IDLE;
         end
         default: state_nxt = LP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LP_IDLE;
         line_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         mask_q      <= '0;
         beat_cnt    <= '0;
         wr_done_q   <= 1'b0;
         err_stray_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         mask_q    <= mask_nxt;
         wr_done_q <= (state == LP_WR_CMD) && (state_nxt == LP_IDLE);
         if (state == LP_IDLE && req_valid) begin
            line_q   <= req_line;
            wdata_q  <= req_wdata;
            beat_cnt <= '0;
         end
         if (sd_rdata_val) begin
            if (state == LP_RD_DATA) begin
               rdata_q[{beat_cnt, 4'b0000} +: WORD_W] <= sd_rdata;
               beat_cnt <= beat_cnt + 1'b1;
            end else begin
               err_stray_q <= 1'b1;
            end
         end
      end
   end

   // Strobes are masked by reset so nothing reaches the controller while it is asserted.
   assign req_ready = (state == LP_IDLE) && !reset;
   assign sd_read   = (state == LP_RD_CMD) && !reset;
   assign sd_write  = (state == LP_WR_CMD) && (mask_q != '0) && !reset;
   assign rsp_valid = (state == LP_RSP) && !reset;
   assign sd_addr   = sd_read  ? {line_q, {OFFS_W{1'b0}}} :
                      sd_write ? {line_q, idx} : '0;
   assign sd_wdata  = sd_write ? wdata_q[{idx, 4'b0000} +: WORD_W] : '0;
   assign rsp_rdata = rdata_q;
   assign wr_done   = wr_done_q;
   assign err_stray = err_stray_q;

endmodule
